jtag_cmd_decoder: RTL and testbench
===================================

Name: jtag_cmd_decoder

Overview:
- Packet decoder sitting directly downstream of the JTAG byte receiver; consumes its byte/done stream.
- Parses command packets and drives a byte-wide buffer port (CNN weight/image buffer).
- Sources the response byte held by the JTAG byte transmitter.
- Full duplex: host clocks dummy bytes in while read data shifts out.

Parameters:
- ADDR_W, 16, buffer address width; packet carries 16 address bits, upper bits beyond ADDR_W are discarded.

Ports:
- TCK  in  1  shift clock; sole clock of the block.
- TRSTn  in  1  asynchronous active-low reset.
- TCS  in  1  frame select; high = no frame/abort, low = packet in progress.
- rx_data  in  8  byte from receiver, valid when rx_done=1.
- rx_done  in  1  one-cycle pulse per received byte.
- tx_data  out  8  byte presented to transmitter; held stable between tx_done pulses.
- tx_done  in  1  one-cycle pulse when the transmitter finishes a byte.
- mem_addr  out  ADDR_W  buffer address.
- mem_wdata  out  8  buffer write data.
- mem_we  out  1  one-cycle write strobe.
- mem_re  out  1  one-cycle read strobe; mem_rdata valid the following cycle.
- mem_rdata  in  8  buffer read data.
- busy  out  1  high whenever state != IDLE.
- err  out  1  sticky protocol-error flag.
- pkt_done  out  1  one-cycle pulse on packet completion.

Behaviour:
- Reset (TRSTn=0, async): state IDLE; tx_data=8'h00; mem_addr=0; mem_wdata=0; mem_we=0; mem_re=0; err=0; pkt_done=0; busy=0; remaining count=0.
- Packet format: OPCODE, ADDR_HI, ADDR_LO, LEN, then payload. Transfer count = LEN+1 (1..256).
- Opcodes: 8'h01 WRITE, 8'h02 READ, 8'h03 STATUS.
- Bytes are consumed only on cycles with rx_done=1.
- States: IDLE, ADDR_HI, ADDR_LO, LEN, WDATA, RFETCH, RWAIT, RSEND, ERROR.
- IDLE + rx_done:
  - WRITE/READ -> ADDR_HI; latch the opcode.
  - STATUS -> tx_data={6'b0,err,busy_hist}, where busy_hist is 1 if the previous packet was aborted. Also clear err, pulse pkt_done, stay in IDLE.
  - Any other value -> err=1, go to ERROR.
- ADDR_HI -> ADDR_LO -> LEN: load the address bytes, then remaining=LEN.
  - After LEN: WRITE -> WDATA; READ -> RFETCH.
- WDATA + rx_done:
  - mem_wdata=rx_data, mem_we=1 for exactly one cycle at the current mem_addr.
  - Then increment mem_addr (wraps modulo 2^ADDR_W) and decrement remaining.
  - On the last byte (remaining==0 at strobe): pulse pkt_done, go to IDLE.
- READ path:
  - RFETCH: mem_re=1 for one cycle -> RWAIT.
  - RWAIT: tx_data<=mem_rdata -> RSEND.
  - RSEND waits for tx_done. On tx_done: if remaining==0, pulse pkt_done -> IDLE; else increment mem_addr, decrement remaining -> RFETCH.
  - rx bytes during a read are dummies and are ignored.
  - Latency from the LEN rx_done to a valid tx_data is 3 TCK cycles.
- ERROR: all rx_done ignored; exits to IDLE only on TCS=1.
- TCS=1 (sampled on TCK):
  - Returns the block to IDLE from any state; TCS has priority over a same-cycle rx_done or tx_done.
  - Writes already strobed persist.
  - busy_hist=1 if the abort came from a non-IDLE state other than ERROR; otherwise 0.
  - err is unchanged.
- Strobe exclusivity: mem_we and mem_re are never high together and are never high two consecutive cycles in WDATA.
- tx_data changes only in RWAIT, on a STATUS opcode, or at reset.
- pkt_done and mem_we are never asserted in the same cycle except on the final WDATA byte.

Decomposition:
- Shared package jtag_pkg:
  - opcode constants OP_WRITE/OP_READ/OP_STATUS;
  - state enum localparams;
  - packet header length constant (4).
- One natural sub-module: jtag_addr_ctr, an address/remaining-count register pair with load, increment-with-wrap, and last-flag output. It is shared by the write and read paths.

Test Plan:
- WRITE to 16'h0010: bytes 01,00,10,02,AA,BB,CC -> three mem_we pulses, addr 0010/0011/0012, data AA/BB/CC; pkt_done with the third strobe; err=0.
- READ from 16'h00FE, ADDR_W=8, LEN=02, memory preloaded 11/22/33 at FE/FF/00 -> tx_data sequence 11,22,33, each held until tx_done; address wraps FF->00; pkt_done after the third tx_done.
- Opcode 8'h7F followed by 4 bytes -> err=1, no mem_we/mem_re, busy=1 until TCS=1.
  - Subsequent STATUS -> tx_data=8'h02, and err clears the following cycle.
- WRITE with LEN=05, TCS raised after 2 payload bytes -> exactly 2 mem_we pulses, IDLE, busy=0.
  - Next STATUS gives tx_data=8'h01.
- TRSTn pulled low mid-READ in RSEND -> all outputs at reset values immediately (asynchronous), no further mem_re.
- WRITE with LEN=FF -> 256 mem_we pulses, addr wraps correctly, single pkt_done on the 256th.

Source files
------------

// File: rtl/jtag_pkg.sv
// jtag_pkg: opcodes, FSM state encoding and packet constants shared by the JTAG command decoder.
//   OP_WRITE / OP_READ / OP_STATUS : first byte of every packet
//   HDR_LEN                        : header bytes before the payload (opcode, addr hi, addr lo, len)
//   state_t                        : decoder FSM states
package jtag_pkg;
    localparam logic [7:0] OP_WRITE  = 8'h01;
    localparam logic [7:0] OP_READ   = 8'h02;
    localparam logic [7:0] OP_STATUS = 8'h03;
    localparam int HDR_LEN = 4;
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_HI, S_ADDR_LO, S_LEN, S_WDATA, S_RFETCH, S_RWAIT, S_RSEND, S_ERROR
    } state_t;
endpackage

// File: rtl/jtag_cmd_decoder_if.sv
// jtag_cmd_decoder_if: byte streams and buffer port around the JTAG command decoder.
//   rx_data/rx_done : byte stream from the JTAG receiver (rx_done is a one-cycle pulse)
//   tx_data/tx_done : response byte for the transmitter and its byte-finished pulse
//   mem_*           : byte-wide buffer port; mem_rdata is valid the cycle after mem_re
//   master          : decoder side; slave : receiver/transmitter/buffer side
interface jtag_cmd_decoder_if #(parameter int ADDR_W = 16);
    logic [7:0]        rx_data;
    logic              rx_done;
    logic [7:0]        tx_data;
    logic              tx_done;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [7:0]        mem_rdata;
    modport master (
        input  rx_data, rx_done, tx_done, mem_rdata,
        output tx_data, mem_addr, mem_wdata, mem_we, mem_re
    );
    modport slave (
        output rx_data, rx_done, tx_done, mem_rdata,
        input  tx_data, mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/jtag_addr_ctr.sv
// jtag_addr_ctr: buffer address and remaining-transfer count shared by the write and read paths.
//   clk, rst_n      : clock and asynchronous active-low reset
//   ld_addr/addr_in : load the packet address
//   ld_cnt/cnt_in   : load the remaining count (LEN)
//   inc             : step to the next byte (address wraps modulo 2^ADDR_W, count decrements)
//   addr            : current buffer address
//   last            : current byte is the final one of the packet
module jtag_addr_ctr #(parameter int ADDR_W = 16) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_addr,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              ld_cnt,
    input  logic [7:0]        cnt_in,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    logic [7:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            addr <= '0;
            cnt  <= '0;
        end else begin
            addr <= ld_addr ? addr_in : inc ? addr + 1'b1 : addr;
            cnt  <= ld_cnt ? cnt_in : inc ? cnt - 1'b1 : cnt;
        end
    assign last = cnt == 8'd0;
endmodule

// File: rtl/jtag_cmd_decoder.sv
// jtag_cmd_decoder: parses JTAG command packets into buffer writes/reads and STATUS replies.
//   TCK, TRSTn : shift clock and asynchronous active-low reset
//   TCS        : frame select; high aborts any packet and returns to IDLE
//   bus        : receiver/transmitter byte streams and buffer port (master side)
//   busy       : FSM is not IDLE
//   err        : sticky protocol error, cleared by a STATUS packet
//   pkt_done   : one-cycle pulse when a packet completes
module jtag_cmd_decoder import jtag_pkg::*; #(parameter int ADDR_W = 16) (
    input  logic               TCK,
    input  logic               TRSTn,
    input  logic               TCS,
    jtag_cmd_decoder_if.master bus,
    output logic               busy,
    output logic               err,
    output logic               pkt_done
);
    state_t      state, state_n;
    logic        rd_op, rd_op_n, busy_hist, hist_n, err_n, pkt_n, we_n;
    logic        ld_addr, ld_cnt, rd_inc, last;
    logic [7:0]  addr_hi, hi_n, tx_n, wdata_n;
    logic [15:0] pkt_addr;
    logic        unused_addr_bits;
    // Address bits above ADDR_W are carried by the packet but deliberately dropped.
    assign pkt_addr         = {addr_hi, bus.rx_data};
    assign unused_addr_bits = ^pkt_addr;
    assign busy             = state != S_IDLE;
    assign bus.mem_re       = state == S_RFETCH;
    // Writes advance the address the cycle after their strobe so the strobe sees the current address.
    jtag_addr_ctr #(.ADDR_W(ADDR_W)) u_ctr (
        .clk(TCK), .rst_n(TRSTn),
        .ld_addr(ld_addr), .addr_in(pkt_addr[ADDR_W-1:0]),
        .ld_cnt(ld_cnt), .cnt_in(bus.rx_data),
        .inc(bus.mem_we | rd_inc),
        .addr(bus.mem_addr), .last(last)
    );
    always_ff @(posedge TCK or negedge TRSTn)
        if (!TRSTn) begin
            state         <= S_IDLE;
            rd_op         <= 1'b0;
            addr_hi       <= 8'h00;
            busy_hist     <= 1'b0;
            err           <= 1'b0;
            pkt_done      <= 1'b0;
            bus.tx_data   <= 8'h00;
            bus.mem_wdata <= 8'h00;
            bus.mem_we    <= 1'b0;
        end else begin
            state         <= state_n;
            rd_op         <= rd_op_n;
            addr_hi       <= hi_n;
            busy_hist     <= hist_n;
            err           <= err_n;
            pkt_done      <= pkt_n;
            bus.tx_data   <= tx_n;
            bus.mem_wdata <= wdata_n;
            bus.mem_we    <= we_n;
        end
    always_comb begin
        state_n = state;
        rd_op_n = rd_op;
        hi_n    = addr_hi;
        hist_n  = busy_hist;
        err_n   = err;
        tx_n    = bus.tx_data;
        wdata_n = bus.mem_wdata;
        pkt_n   = 1'b0;
        we_n    = 1'b0;
        ld_addr = 1'b0;
        ld_cnt  = 1'b0;
        rd_inc  = 1'b0;
        if (TCS) begin
            state_n = S_IDLE;
            if (state != S_IDLE) hist_n = state != S_ERROR;
        end else case (state)
            S_IDLE: if (bus.rx_done) begin
                if (bus.rx_data == OP_WRITE || bus.rx_data == OP_READ) begin
                    state_n = S_ADDR_HI;
                    rd_op_n = bus.rx_data == OP_READ;
                end else if (bus.rx_data == OP_STATUS) begin
                    tx_n   = {6'b0, err, busy_hist};
                    err_n  = 1'b0;
                    hist_n = 1'b0;
                    pkt_n  = 1'b1;
                end else begin
                    err_n   = 1'b1;
                    state_n = S_ERROR;
                end
            end
            S_ADDR_HI: if (bus.rx_done) begin
                hi_n    = bus.rx_data;
                state_n = S_ADDR_LO;
            end
            S_ADDR_LO: if (bus.rx_done) begin
                ld_addr = 1'b1;
                state_n = S_LEN;
            end
            S_LEN: if (bus.rx_done) begin
                ld_cnt  = 1'b1;
                state_n = rd_op ? S_RFETCH : S_WDATA;
            end
            // A byte arriving during the strobe cycle is dropped so strobes never touch.
            S_WDATA: if (bus.rx_done && !bus.mem_we) begin
                we_n    = 1'b1;
                wdata_n = bus.rx_data;
                if (last) begin
                    pkt_n   = 1'b1;
                    hist_n  = 1'b0;
                    state_n = S_IDLE;
                end
            end
            S_RFETCH: state_n = S_RWAIT;
            S_RWAIT: begin
                tx_n    = bus.mem_rdata;
                state_n = S_RSEND;
            end
            S_RSEND: if (bus.tx_done) begin
                if (last) begin
                    pkt_n   = 1'b1;
                    hist_n  = 1'b0;
                    state_n = S_IDLE;
                end else begin
                    rd_inc  = 1'b1;
                    state_n = S_RFETCH;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_jtag_cmd_decoder.sv
// tb_jtag_cmd_decoder: randomized packet stimulus checked against a buffer-level reference model.
module tb_jtag_cmd_decoder;
    import jtag_pkg::*;
    localparam int AW = 8;
    logic TCK = 1'b0, TRSTn = 1'b0, TCS = 1'b1;
    logic busy, err, pkt_done;
    jtag_cmd_decoder_if #(.ADDR_W(AW)) bus();
    jtag_cmd_decoder #(.ADDR_W(AW)) dut (
        .TCK(TCK), .TRSTn(TRSTn), .TCS(TCS), .bus(bus),
        .busy(busy), .err(err), .pkt_done(pkt_done)
    );
    always #5 TCK = ~TCK;

    int n_cmp = 0, n_bad = 0;
    logic [7:0] ref_mem [256];
    logic [7:0] payload [$];

    // Buffer model: synchronous write, registered read, plus a preload port for the bench.
    logic [7:0] mem [256];
    logic       pl_en = 1'b0;
    logic [7:0] pl_addr = 8'h00, pl_data = 8'h00;
    always @(posedge TCK) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    end

    // Observed event log, sampled on the falling edge.
    logic [7:0] wq_a [$], wq_d [$];
    int pkt_cnt = 0, pkt_we = 0, re_cnt = 0, clash = 0;
    logic prev_we = 1'b0;
    always @(negedge TCK) begin
        if (bus.mem_we) begin
            wq_a.push_back(bus.mem_addr);
            wq_d.push_back(bus.mem_wdata);
        end
        if (pkt_done) pkt_cnt++;
        if (pkt_done && bus.mem_we) pkt_we++;
        if (bus.mem_re) re_cnt++;
        if ((bus.mem_we && bus.mem_re) || (bus.mem_we && prev_we)) clash++;
        prev_we = bus.mem_we;
    end

    task automatic tick();
        @(negedge TCK);
        #1;
    endtask

    task automatic clear_log();
        wq_a.delete();
        wq_d.delete();
        pkt_cnt = 0;
        pkt_we  = 0;
        re_cnt  = 0;
        clash   = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        tick();
        bus.rx_done = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic preload(input logic [15:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            pl_addr = 8'(a[7:0] + i);
            pl_data = payload.size() > i ? payload[i] : 8'($urandom);
            ref_mem[pl_addr] = pl_data;
            pl_en = 1'b1;
            tick();
        end
        pl_en = 1'b0;
        payload.delete();
    endtask

    task automatic run_write(input logic [15:0] a, input int len);
        clear_log();
        while (payload.size() < len + 1) payload.push_back(8'($urandom));
        send_byte(OP_WRITE, 2);
        send_byte(a[15:8], 2);
        send_byte(a[7:0], 2);
        send_byte(8'(len), 2);
        for (int i = 0; i <= len; i++) begin
            ref_mem[8'(a[7:0] + i)] = payload[i];
            send_byte(payload[i], 3);
        end
        n_cmp++; if (wq_a.size() != len + 1) begin n_bad++; $display("FAIL write_count: got %0d want %0d", wq_a.size(), len + 1); end
        for (int i = 0; i < wq_a.size() && i <= len; i++) begin
            n_cmp++; if (wq_a[i] !== 8'(a[7:0] + i)) begin n_bad++; $display("FAIL write_addr[%0d]: got %h want %h", i, wq_a[i], 8'(a[7:0] + i)); end
            n_cmp++; if (wq_d[i] !== payload[i]) begin n_bad++; $display("FAIL write_data[%0d]: got %h want %h", i, wq_d[i], payload[i]); end
        end
        n_cmp++; if (pkt_cnt != 1 || pkt_we != 1) begin n_bad++; $display("FAIL write_pkt_done: got %0d pulses (%0d with strobe) want 1 (1)", pkt_cnt, pkt_we); end
        n_cmp++; if (clash != 0 || re_cnt != 0) begin n_bad++; $display("FAIL write_strobes: got clash=%0d re=%0d want 0 0", clash, re_cnt); end
        n_cmp++; if ({err, busy} !== 2'b00) begin n_bad++; $display("FAIL write_end: got err=%b busy=%b want 0 0", err, busy); end
        payload.delete();
    endtask

    task automatic run_read(input logic [15:0] a, input int len);
        clear_log();
        send_byte(OP_READ, 2);
        send_byte(a[15:8], 2);
        send_byte(a[7:0], 2);
        send_byte(8'(len), 0);
        for (int i = 0; i <= len; i++) begin
            logic [7:0] want;
            want = ref_mem[8'(a[7:0] + i)];
            repeat (2) tick();
            n_cmp++; if (bus.tx_data !== want) begin n_bad++; $display("FAIL read_tx[%0d]: got %h want %h", i, bus.tx_data, want); end
            send_byte(8'($urandom), $urandom_range(0, 3));
            n_cmp++; if (bus.tx_data !== want || pkt_cnt != 0) begin n_bad++; $display("FAIL read_hold[%0d]: got %h pkt=%0d want %h pkt=0", i, bus.tx_data, pkt_cnt, want); end
            bus.tx_done = 1'b1;
            tick();
            bus.tx_done = 1'b0;
        end
        repeat (2) tick();
        n_cmp++; if (pkt_cnt != 1 || busy !== 1'b0) begin n_bad++; $display("FAIL read_end: got pkt=%0d busy=%b want 1 0", pkt_cnt, busy); end
        n_cmp++; if (re_cnt != len + 1 || wq_a.size() != 0 || clash != 0) begin n_bad++; $display("FAIL read_strobes: got re=%0d we=%0d clash=%0d want %0d 0 0", re_cnt, wq_a.size(), clash, len + 1); end
    endtask

    task automatic test_reset();
        bus.rx_data = 8'h00; bus.rx_done = 1'b0; bus.tx_done = 1'b0;
        TRSTn = 1'b0; TCS = 1'b1;
        repeat (3) tick();
        n_cmp++; if (bus.tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx: got %h want 00", bus.tx_data); end
        n_cmp++; if (bus.mem_addr !== 8'h00 || bus.mem_wdata !== 8'h00) begin n_bad++; $display("FAIL reset_mem: got addr=%h wdata=%h want 00 00", bus.mem_addr, bus.mem_wdata); end
        n_cmp++; if ({bus.mem_we, bus.mem_re} !== 2'b00) begin n_bad++; $display("FAIL reset_strobes: got %b want 00", {bus.mem_we, bus.mem_re}); end
        n_cmp++; if ({busy, err, pkt_done} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {busy, err, pkt_done}); end
        TRSTn = 1'b1; tick();
        TCS = 1'b0; tick();
    endtask

    task automatic test_write_plan();
        payload = '{8'hAA, 8'hBB, 8'hCC};
        run_write(16'h0010, 2);
    endtask

    task automatic test_read_wrap();
        payload = '{8'h11, 8'h22, 8'h33};
        preload(16'h00FE, 3);
        run_read(16'h00FE, 2);
    endtask

    task automatic test_bad_opcode();
        clear_log();
        send_byte(8'h7F, 2);
        repeat (HDR_LEN) send_byte(8'($urandom), 2);
        n_cmp++; if ({err, busy} !== 2'b11) begin n_bad++; $display("FAIL bad_op_flags: got err=%b busy=%b want 1 1", err, busy); end
        n_cmp++; if (wq_a.size() != 0 || re_cnt != 0) begin n_bad++; $display("FAIL bad_op_strobes: got we=%0d re=%0d want 0 0", wq_a.size(), re_cnt); end
        TCS = 1'b1; repeat (2) tick();
        n_cmp++; if ({err, busy} !== 2'b10) begin n_bad++; $display("FAIL bad_op_abort: got err=%b busy=%b want 1 0", err, busy); end
        TCS = 1'b0; tick();
        send_byte(OP_STATUS, 0);
        n_cmp++; if (bus.tx_data !== 8'h02) begin n_bad++; $display("FAIL status_err: got %h want 02", bus.tx_data); end
        n_cmp++; if (err !== 1'b0 || pkt_cnt != 1) begin n_bad++; $display("FAIL status_clear: got err=%b pkt=%0d want 0 1", err, pkt_cnt); end
        repeat (2) tick();
    endtask

    task automatic test_abort();
        logic [15:0] a;
        logic [7:0]  d0, d1;
        a = 16'($urandom); d0 = 8'($urandom); d1 = 8'($urandom);
        clear_log();
        send_byte(OP_WRITE, 2);
        send_byte(a[15:8], 2);
        send_byte(a[7:0], 2);
        send_byte(8'h05, 2);
        send_byte(d0, 3);
        send_byte(d1, 3);
        ref_mem[a[7:0]] = d0;
        ref_mem[8'(a[7:0] + 1)] = d1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy_before: got %b want 1", busy); end
        bus.rx_data = 8'($urandom); bus.rx_done = 1'b1; TCS = 1'b1;
        tick();
        bus.rx_done = 1'b0;
        tick();
        n_cmp++; if (wq_a.size() != 2) begin n_bad++; $display("FAIL abort_count: got %0d want 2", wq_a.size()); end
        else begin
            n_cmp++; if (wq_a[1] !== 8'(a[7:0] + 1) || wq_d[1] !== d1) begin n_bad++; $display("FAIL abort_second: got %h/%h want %h/%h", wq_a[1], wq_d[1], 8'(a[7:0] + 1), d1); end
        end
        n_cmp++; if ({busy, err} !== 2'b00 || pkt_cnt != 0) begin n_bad++; $display("FAIL abort_idle: got busy=%b err=%b pkt=%0d want 0 0 0", busy, err, pkt_cnt); end
        TCS = 1'b0; tick();
        send_byte(OP_STATUS, 2);
        n_cmp++; if (bus.tx_data !== 8'h01) begin n_bad++; $display("FAIL status_abort: got %h want 01", bus.tx_data); end
        run_write(a ^ 16'h0080, 1);
        send_byte(OP_STATUS, 2);
        n_cmp++; if (bus.tx_data !== 8'h00) begin n_bad++; $display("FAIL status_clean: got %h want 00", bus.tx_data); end
    endtask

    task automatic test_reset_mid_read();
        logic [15:0] a;
        int r0;
        a = {8'($urandom), 8'($urandom_range(1, 250))};
        for (int i = 0; i < 4; i++) payload.push_back(8'($urandom_range(1, 255)));
        preload(a, 4);
        clear_log();
        send_byte(OP_READ, 2);
        send_byte(a[15:8], 2);
        send_byte(a[7:0], 2);
        send_byte(8'h03, 0);
        repeat (2) tick();
        n_cmp++; if (busy !== 1'b1 || bus.tx_data !== ref_mem[a[7:0]]) begin n_bad++; $display("FAIL rsend_entry: got busy=%b tx=%h want 1 %h", busy, bus.tx_data, ref_mem[a[7:0]]); end
        r0 = re_cnt;
        TRSTn = 1'b0;
        #1;
        n_cmp++; if (bus.tx_data !== 8'h00 || bus.mem_addr !== 8'h00) begin n_bad++; $display("FAIL async_reset_data: got tx=%h addr=%h want 00 00", bus.tx_data, bus.mem_addr); end
        n_cmp++; if ({busy, err, pkt_done, bus.mem_we, bus.mem_re} !== 5'b0) begin n_bad++; $display("FAIL async_reset_flags: got %b want 00000", {busy, err, pkt_done, bus.mem_we, bus.mem_re}); end
        repeat (3) tick();
        TRSTn = 1'b1;
        repeat (6) tick();
        n_cmp++; if (re_cnt != r0 || busy !== 1'b0) begin n_bad++; $display("FAIL reset_quiet: got re=%0d busy=%b want %0d 0", re_cnt, busy, r0); end
    endtask

    task automatic test_long_write();
        run_write(16'($urandom), 255);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            logic [15:0] a;
            int len;
            a = 16'($urandom);
            len = $urandom_range(0, 6);
            run_write(a, len);
            run_read(a ^ 16'hFF00, len);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_plan();
        test_read_wrap();
        test_bad_opcode();
        test_abort();
        test_reset_mid_read();
        test_long_write();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
